// File: rtl/hack_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hack_ram_arbiter
// Description : Two-master arbiter for the Hack SoC single-port data RAM.
//               The CPU has fixed priority. A streak counter forces one DMA
//               slot after MAX_CPU_STREAK consecutive CPU grants while DMA
//               waits. One-cycle-latency read data is steered back to the
//               master that issued the read.
//               Optional build macro HACK_ARB_STATS_EN adds the saturating
//               DMA wait-cycle counter output o_dma_wait_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_ram_arbiter #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 16,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    // CPU data port
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    // Secondary master (DMA / debug / loader)
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    output logic              o_dma_gnt,
    output logic              o_dma_rvalid,
    output logic [DATA_W-1:0] o_dma_rdata,
`ifdef HACK_ARB_STATS_EN
    output logic [15:0]       o_dma_wait_cnt,
`endif
    // RAM port
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // Streak counter must be able to hold the value MAX_CPU_STREAK itself.
    localparam int STREAK_W = (MAX_CPU_STREAK < 1) ? 1 : $clog2(MAX_CPU_STREAK + 1);
    localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);
    localparam logic [STREAK_W-1:0] C_STREAK_ONE = STREAK_W'(1);

    localparam logic [0:0] S_CPU = 1'b0;  // CPU has priority
    localparam logic [0:0] S_DMA = 1'b1;  // one forced DMA slot

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_nxt;
    logic [STREAK_W-1:0] w_streak_inc;
    logic                w_cpu_gnt;
    logic                w_dma_gnt;
    logic                r_tag_rd;    // a read was granted last cycle
    logic                r_tag_dma;   // owner of that read: 1 = DMA, 0 = CPU

    assign w_streak_inc = r_streak + C_STREAK_ONE;

    // State and streak registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_CPU;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Grant decision, next state and next streak value
    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_dma_gnt    = 1'b0;
        w_state_nxt  = S_CPU;
        w_streak_nxt = r_streak;
        if (!i_reset) begin
            case (r_state)
                S_CPU: begin
                    if (i_cpu_req) begin
                        w_cpu_gnt = 1'b1;
                    end else if (i_dma_req) begin
                        w_dma_gnt = 1'b1;
                    end
                    if (w_cpu_gnt && i_dma_req) begin
                        w_streak_nxt = w_streak_inc;
                        if (w_streak_inc == C_STREAK_MAX) begin
                            w_state_nxt = S_DMA;
                        end
                    end
                end
                S_DMA: begin
                    // CPU is locked out for this single cycle
                    w_dma_gnt   = i_dma_req;
                    w_state_nxt = S_CPU;
                end
                default: begin
                    w_state_nxt = S_CPU;
                end
            endcase
            if (!i_dma_req || w_dma_gnt) begin
                w_streak_nxt = '0;
            end
        end
    end

    // RAM port mux driven by whichever master holds the grant
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_cpu_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_cpu_we;
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
        end else if (w_dma_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_dma_we;
            o_mem_addr  = i_dma_addr;
            o_mem_wdata = i_dma_wdata;
        end
    end

    // Owner tag for the read issued this cycle; reset drops any in-flight read
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tag_rd  <= 1'b0;
            r_tag_dma <= 1'b0;
        end else begin
            r_tag_rd  <= (w_cpu_gnt && !i_cpu_we) || (w_dma_gnt && !i_dma_we);
            r_tag_dma <= w_dma_gnt;
        end
    end

    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_dma_gnt    = w_dma_gnt;
    assign o_cpu_rvalid = r_tag_rd && !r_tag_dma;
    assign o_dma_rvalid = r_tag_rd &&  r_tag_dma;
    assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
    assign o_dma_rdata  = o_dma_rvalid ? i_mem_rdata : '0;

`ifdef HACK_ARB_STATS_EN
    logic [15:0] r_dma_wait_cnt;

    // Saturating count of cycles the DMA master spends waiting for a grant
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dma_wait_cnt <= '0;
        end else if (i_dma_req && !w_dma_gnt && (r_dma_wait_cnt != 16'hFFFF)) begin
            r_dma_wait_cnt <= r_dma_wait_cnt + 16'd1;
        end
    end

    assign o_dma_wait_cnt = r_dma_wait_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hack_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_ram_arbiter
// Description : Directed self-checking bench for hack_ram_arbiter with a
//               behavioural one-cycle-latency RAM. Stats checks are compiled
//               only when HACK_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_ram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, dma_req, dma_we;
    logic [ADDR_W-1:0] cpu_addr, dma_addr;
    logic [DATA_W-1:0] cpu_wdata, dma_wdata;
    logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] cpu_rdata, dma_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef HACK_ARB_STATS_EN
    logic [15:0]       dma_wait_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] ram [0:15];

    always #5 clk = ~clk;

    hack_ram_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_CPU_STREAK (4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_rdata  (cpu_rdata),
        .i_dma_req    (dma_req),
        .i_dma_we     (dma_we),
        .i_dma_addr   (dma_addr),
        .i_dma_wdata  (dma_wdata),
        .o_dma_gnt    (dma_gnt),
        .o_dma_rvalid (dma_rvalid),
        .o_dma_rdata  (dma_rdata),
`ifdef HACK_ARB_STATS_EN
        .o_dma_wait_cnt (dma_wait_cnt),
`endif
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    // Behavioural single-port RAM, 16 words, one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step to the next drive point (falling edge)
    task automatic next_cyc();
        @(negedge clk);
    endtask

    // Expected DMA-grant pattern under full contention, cycle 0 first
    logic [11:0] exp_cont;
    logic [4:0]  exp_after;

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 16'h0100 + 16'(i);
        mem_rdata = '0;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        exp_cont  = 12'b0000_1000_0100 >> 0;
        // cycle index i -> bit i : C,C,C,C,D,C,C,C,C,D,C,C
        exp_cont  = 12'b0010_0001_0000;
        exp_after = 5'b10000;

        // ---- reset state: requests asserted but everything idle ----
        repeat (2) next_cyc();
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);

        // ---- test 1: CPU write 30 to addr 0, then read it back ----
        next_cyc();
        rst = 1'b0; dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 0; cpu_wdata = 16'd30;
        #1;
        chk("t1_wr_gnt", {cpu_gnt, dma_gnt}, 2'b10);
        chk("t1_wr_mem", {mem_en, mem_we, 1'b0, mem_addr, mem_wdata}, {2'b11, 16'h0000, 16'd30});
        next_cyc();
        cpu_we = 1'b0;
        #1;
        chk("t1_rd_gnt", {cpu_gnt, mem_en, mem_we}, 3'b110);
        chk("t1_no_wr_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        next_cyc();
        cpu_req = 1'b0;
        #1;
        chk("t1_rvalid", {cpu_rvalid, dma_rvalid}, 2'b10);
        chk("t1_rdata", cpu_rdata, 30);
        chk("t1_dma_rdata", dma_rdata, 0);
        chk("t1_idle_mem", {mem_en, mem_we, 1'b0, mem_addr, mem_wdata}, 0);

        // ---- test 2: full contention for 12 cycles ----
        for (int i = 0; i < 12; i++) begin
            next_cyc();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3;
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7;
            #1;
            chk($sformatf("t2_gnt_%0d", i), {cpu_gnt, dma_gnt}, {~exp_cont[i], exp_cont[i]});
            if (i > 0) begin
                chk($sformatf("t2_rv_%0d", i), {cpu_rvalid, dma_rvalid},
                    {~exp_cont[i-1], exp_cont[i-1]});
                chk($sformatf("t2_rd_%0d", i), {cpu_rdata, dma_rdata},
                    exp_cont[i-1] ? {16'h0, 16'h0107} : {16'h0103, 16'h0});
            end
        end
`ifdef HACK_ARB_STATS_EN
        // 12 contended cycles, 2 of them granted to DMA
        next_cyc();
        chk("t6_wait_cnt", dma_wait_cnt, 10);
`endif

        // ---- test 3: DMA alone reading 5,6,7 back to back ----
        next_cyc();
        cpu_req = 1'b0; dma_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            dma_req  = (i < 3);
            dma_addr = ADDR_W'(5 + i);
            #1;
            chk($sformatf("t3_gnt_%0d", i), {cpu_gnt, dma_gnt}, {1'b0, (i < 3) ? 1'b1 : 1'b0});
            if (i > 0) begin
                chk($sformatf("t3_rv_%0d", i), {cpu_rvalid, dma_rvalid}, {1'b0, (i < 4) ? 1'b1 : 1'b0});
                chk($sformatf("t3_rd_%0d", i), dma_rdata, (i < 4) ? 32'(16'h0104 + 16'(i)) : 32'h0);
            end
        end

        // ---- test 4: forced slot arrives after DMA withdrew ----
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 2; dma_addr = 4;
            #1;
            chk($sformatf("t4_pre_%0d", i), {cpu_gnt, dma_gnt}, 2'b10);
        end
        next_cyc();
        dma_req = 1'b0;
        #1;
        chk("t4_slot_idle", {cpu_gnt, dma_gnt, mem_en}, 3'b000);
        // streak must have restarted from zero: four CPU grants before the next slot
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            dma_req = 1'b1;
            #1;
            chk($sformatf("t4_post_%0d", i), {cpu_gnt, dma_gnt}, {~exp_after[i], exp_after[i]});
        end

        // ---- test 5: reset the cycle after a CPU read grant ----
        next_cyc();
        dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 0;
        #1;
        chk("t5_rd_gnt", cpu_gnt, 1);
        next_cyc();
        rst = 1'b1;
        #1;
        chk("t5_rv_in_rst", {cpu_rvalid, dma_rvalid}, 0);
        chk("t5_gnt_in_rst", {cpu_gnt, mem_en}, 0);
        next_cyc();
        #1;
        chk("t5_rv_in_rst2", cpu_rvalid, 0);
        next_cyc();
        rst = 1'b0; cpu_req = 1'b0;
        #1;
        chk("t5_rv_after", cpu_rvalid, 0);
        next_cyc();
        cpu_req = 1'b1; cpu_addr = 0;
        #1;
        chk("t5_again_gnt", cpu_gnt, 1);
        next_cyc();
        cpu_req = 1'b0;
        #1;
        chk("t5_again_rv", cpu_rvalid, 1);
        chk("t5_again_rd", cpu_rdata, 30);

`ifdef HACK_ARB_STATS_EN
        // ---- counter saturation with the CPU winning ----
        next_cyc();
        force dut.r_dma_wait_cnt = 16'hFFFE;
        release dut.r_dma_wait_cnt;
        cpu_req = 1'b1; dma_req = 1'b1;
        next_cyc();
        chk("t6_cnt_ffff", dma_wait_cnt, 16'hFFFF);
        next_cyc();
        next_cyc();
        chk("t6_cnt_sat", dma_wait_cnt, 16'hFFFF);
        cpu_req = 1'b0; dma_req = 1'b0;
`endif

        next_cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
